exc_ctrl: RTL and testbench

EXC_CTRL -- requirements
Module: exc_ctrl

---
 rtl/exc_ctrl_pkg.sv | 31 +++
 rtl/exc_prio.sv | 45 ++++
 rtl/exc_ctrl.sv | 146 ++++++++++++++
 tb/tb_exc_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared processor package: exception FSM state encoding, cause codes and
// the default exception vector table base.
// Latency: n/a (types and constants only).  Backpressure: n/a.
package exc_ctrl_pkg;

    // Exception controller states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTER   = 3'd1,
        ST_VECTOR  = 3'd2,
        ST_HANDLER = 3'd3,
        ST_RETURN  = 3'd4
    } exc_state_e;

    // Cause codes.  External IRQ line i reports CAUSE_IRQ0 + i.
    localparam logic [3:0] CAUSE_NONE    = 4'd0;
    localparam logic [3:0] CAUSE_ILL     = 4'd1;
    localparam logic [3:0] CAUSE_PRIV    = 4'd2;
    localparam logic [3:0] CAUSE_SYSCALL = 4'd3;
    localparam logic [3:0] CAUSE_IRQ0    = 4'd8;

    // Default base address of the exception vector table.
    localparam logic [31:0] EXC_VEC_BASE = 32'h0000_0080;

    // Each vector table entry is 16 bytes, indexed by cause code.
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [3:0]  cause);
        return base + {24'b0, cause, 4'b0000};
    endfunction

endpackage

// File: rtl/exc_prio.sv
// Exception priority encoder: picks the winning event and its cause code.
// Latency: combinational, zero cycles.  Backpressure: none (pure function of inputs).
// Ports: i_ill_instr/i_priv_viol/i_syscall sync events, i_irq/i_ie interrupts,
//        o_valid any qualified event, o_cause cause code of the winner.
module exc_prio
    import exc_ctrl_pkg::*;
#(
    parameter int NIRQ = 4   // at most 8 so that 8+i fits the 4-bit cause
) (
    input  logic            i_ill_instr,
    input  logic            i_priv_viol,
    input  logic            i_syscall,
    input  logic [NIRQ-1:0] i_irq,
    input  logic            i_ie,
    output logic            o_valid,
    output logic [3:0]      o_cause
);

    // Assignments run from lowest to highest priority so the last match wins.
    always_comb begin
        o_valid = 1'b0;
        o_cause = CAUSE_NONE;
        if (i_ie) begin
            for (int i = NIRQ - 1; i >= 0; i--) begin
                if (i_irq[i]) begin
                    o_valid = 1'b1;
                    o_cause = CAUSE_IRQ0 + 4'(i);
                end
            end
        end
        if (i_syscall) begin
            o_valid = 1'b1;
            o_cause = CAUSE_SYSCALL;
        end
        if (i_priv_viol) begin
            o_valid = 1'b1;
            o_cause = CAUSE_PRIV;
        end
        if (i_ill_instr) begin
            o_valid = 1'b1;
            o_cause = CAUSE_ILL;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception controller: takes exceptions/interrupts, redirects fetch to the
// vector table, and handles return-from-exception back to the saved PC.
// Latency: event to exception/flush strobe one cycle; vec_valid the cycle after.
// Backpressure: vec_valid/vec_pc held stable until pc_ack; events ignored meanwhile.
// Ports: clk/rst (async active-low), irq/ie/ill_instr/priv_viol/syscall events,
//        rfe_req, pc_in, pc_ack; exception/rfe/flush strobes, vec_valid/vec_pc
//        redirect, epc/cause saved state.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter int          NIRQ     = 4,
    parameter logic [31:0] VEC_BASE = EXC_VEC_BASE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq,
    input  logic            ie,
    input  logic            ill_instr,
    input  logic            priv_viol,
    input  logic            syscall,
    input  logic            rfe_req,
    input  logic [31:0]     pc_in,
    input  logic            pc_ack,
    output logic            exception,
    output logic            rfe,
    output logic            flush,
    output logic            vec_valid,
    output logic [31:0]     vec_pc,
    output logic [31:0]     epc,
    output logic [3:0]      cause
);

    exc_state_e  r_state;
    exc_state_e  w_state_nxt;

    logic        w_evt_vld;
    logic [3:0]  w_evt_cause;

    logic        r_exception;
    logic        r_rfe;
    logic        r_flush;
    logic        r_vec_valid;
    logic [31:0] r_vec_pc;
    logic [31:0] r_epc;
    logic [3:0]  r_cause;

    logic        w_exception_nxt;
    logic        w_rfe_nxt;
    logic        w_flush_nxt;
    logic        w_vec_valid_nxt;
    logic [31:0] w_vec_pc_nxt;

    exc_prio #(
        .NIRQ (NIRQ)
    ) u_prio (
        .i_ill_instr (ill_instr),
        .i_priv_viol (priv_viol),
        .i_syscall   (syscall),
        .i_irq       (irq),
        .i_ie        (ie),
        .o_valid     (w_evt_vld),
        .o_cause     (w_evt_cause)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.  Events are only looked at in IDLE and HANDLER; in the
    // other states the pipeline is being flushed and anything seen is stale.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_evt_vld) w_state_nxt = ST_ENTER;
            end
            ST_ENTER: begin
                w_state_nxt = ST_VECTOR;
            end
            ST_VECTOR: begin
                if (pc_ack) w_state_nxt = ST_HANDLER;
            end
            ST_HANDLER: begin
                // A new exception beats a simultaneous rfe; the rfe is dropped.
                if (w_evt_vld)    w_state_nxt = ST_ENTER;
                else if (rfe_req) w_state_nxt = ST_RETURN;
            end
            ST_RETURN: begin
                if (pc_ack) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output logic: computes the value each output flop takes on the coming
    // edge, so the strobes line up with the state they belong to while still
    // coming straight out of flops.
    always_comb begin
        w_exception_nxt = (w_state_nxt == ST_ENTER);
        w_rfe_nxt       = (r_state == ST_HANDLER) && (w_state_nxt == ST_RETURN);
        w_flush_nxt     = w_exception_nxt || w_rfe_nxt;
        w_vec_valid_nxt = (w_state_nxt == ST_VECTOR) || (w_state_nxt == ST_RETURN);
        w_vec_pc_nxt    = 32'h0;
        // r_cause / r_epc are already settled when these states are entered.
        if (w_state_nxt == ST_VECTOR) w_vec_pc_nxt = vec_addr(VEC_BASE, r_cause);
        if (w_state_nxt == ST_RETURN) w_vec_pc_nxt = r_epc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exception <= 1'b0;
            r_rfe       <= 1'b0;
            r_flush     <= 1'b0;
            r_vec_valid <= 1'b0;
            r_vec_pc    <= 32'h0;
            r_epc       <= 32'h0;
            r_cause     <= CAUSE_NONE;
        end else begin
            r_exception <= w_exception_nxt;
            r_rfe       <= w_rfe_nxt;
            r_flush     <= w_flush_nxt;
            r_vec_valid <= w_vec_valid_nxt;
            r_vec_pc    <= w_vec_pc_nxt;
            if (w_exception_nxt) begin
                r_epc   <= pc_in;
                r_cause <= w_evt_cause;
            end
        end
    end

    assign exception = r_exception;
    assign rfe       = r_rfe;
    assign flush     = r_flush;
    assign vec_valid = r_vec_valid;
    assign vec_pc    = r_vec_pc;
    assign epc       = r_epc;
    assign cause     = r_cause;

endmodule

// File: tb/tb_exc_ctrl.sv
// Testbench for exc_ctrl: directed scenarios followed by randomized traffic,
// all checked against a behavioural model of the exception sequence.
module tb_exc_ctrl;

    localparam logic [31:0] BASE = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq;
    logic        ie, ill_instr, priv_viol, syscall, rfe_req, pc_ack;
    logic [31:0] pc_in;
    logic        exception, rfe, flush, vec_valid;
    logic [31:0] vec_pc, epc;
    logic [3:0]  cause;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: phase of the exception sequence as the spec describes it.
    // 0 idle, 1 entering, 2 vectoring, 3 in handler, 4 returning.
    int          m_ph;
    bit          m_ret_first;
    logic [31:0] m_epc;
    logic [3:0]  m_cause;

    exc_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .irq       (irq),
        .ie        (ie),
        .ill_instr (ill_instr),
        .priv_viol (priv_viol),
        .syscall   (syscall),
        .rfe_req   (rfe_req),
        .pc_in     (pc_in),
        .pc_ack    (pc_ack),
        .exception (exception),
        .rfe       (rfe),
        .flush     (flush),
        .vec_valid (vec_valid),
        .vec_pc    (vec_pc),
        .epc       (epc),
        .cause     (cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Winning cause code, 0 when nothing qualifies.
    function automatic int winner();
        if (ill_instr) return 1;
        if (priv_viol) return 2;
        if (syscall)   return 3;
        if (ie) begin
            for (int i = 0; i < 4; i++) if (irq[i]) return 8 + i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_ret_first = 0; m_epc = 0; m_cause = 0;
    endtask

    task automatic model_step();
        int w;
        w = winner();
        m_ret_first = 0;
        case (m_ph)
            0: if (w != 0) begin m_ph = 1; m_epc = pc_in; m_cause = 4'(w); end
            1: m_ph = 2;
            2: if (pc_ack) m_ph = 3;
            3: begin
                if (w != 0) begin m_ph = 1; m_epc = pc_in; m_cause = 4'(w); end
                else if (rfe_req) begin m_ph = 4; m_ret_first = 1; end
            end
            4: if (pc_ack) m_ph = 0;
            default: m_ph = 0;
        endcase
    endtask

    task automatic check_all();
        logic [31:0] exp_pc;
        exp_pc = (m_ph == 2) ? BASE + 32'(m_cause) * 16 : (m_ph == 4) ? m_epc : 32'h0;
        chk("exception", 32'(exception), 32'(m_ph == 1));
        chk("rfe",       32'(rfe),       32'(m_ph == 4 && m_ret_first));
        chk("flush",     32'(flush),     32'(m_ph == 1 || (m_ph == 4 && m_ret_first)));
        chk("vec_valid", 32'(vec_valid), 32'(m_ph == 2 || m_ph == 4));
        chk("vec_pc",    vec_pc,         exp_pc);
        chk("epc",       epc,            m_epc);
        chk("cause",     32'(cause),     32'(m_cause));
    endtask

    task automatic clear_in();
        irq = 0; ill_instr = 0; priv_viol = 0; syscall = 0; rfe_req = 0; pc_ack = 0;
    endtask

    // Called just after a falling edge with inputs set; returns at the next
    // falling edge after checking outputs following the rising edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; ie = 0; pc_in = 0;
        clear_in();
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b1;

        // Interrupt on line 2.
        ie = 1; irq = 4'b0100; pc_in = 32'h0000_1000;
        cycle();
        clear_in();
        chk("t36_exception", 32'(exception), 32'h1);
        chk("t36_cause",     32'(cause),     32'd10);
        chk("t36_epc",       epc,            32'h0000_1000);
        cycle();
        chk("t36_exc_once",  32'(exception), 32'h0);
        chk("t36_vec_pc",    vec_pc,         32'h0000_0120);
        cycle();                              // VECTOR held without ack
        chk("t36_vec_hold",  32'(vec_valid), 32'h1);
        pc_ack = 1; cycle(); clear_in();      // -> HANDLER

        // Return with acknowledge arriving on the third RETURN cycle.
        rfe_req = 1; pc_in = 32'h0000_5550;
        cycle(); clear_in();
        chk("t39_rfe",       32'(rfe),       32'h1);
        chk("t39_vec_pc",    vec_pc,         32'h0000_1000);
        cycle();
        chk("t39_rfe_once",  32'(rfe),       32'h0);
        chk("t39_valid2",    32'(vec_valid), 32'h1);
        cycle();
        chk("t39_valid3",    32'(vec_valid), 32'h1);
        pc_ack = 1; cycle(); clear_in();
        chk("t39_idle",      32'(vec_valid), 32'h0);

        // Simultaneous sync events plus interrupt: illegal instruction wins.
        ill_instr = 1; syscall = 1; irq = 4'b0001; ie = 1; pc_in = 32'h0000_2000;
        cycle(); clear_in();
        chk("t37_cause",     32'(cause),     32'd1);
        cycle();
        chk("t37_vec_pc",    vec_pc,         32'h0000_0090);
        pc_ack = 1; cycle(); clear_in();      // -> HANDLER

        // syscall beats rfe_req in the handler.
        syscall = 1; rfe_req = 1; pc_in = 32'h0000_2400;
        cycle(); clear_in();
        chk("t40_cause",     32'(cause),     32'd3);
        chk("t40_rfe",       32'(rfe),       32'h0);
        chk("t40_exception", 32'(exception), 32'h1);
        cycle();
        chk("t40_rfe_later", 32'(rfe),       32'h0);
        pc_ack = 1; cycle(); clear_in();
        rfe_req = 1; cycle(); clear_in();
        pc_ack = 1; cycle(); clear_in();      // -> IDLE

        // Masked interrupts are ignored.
        ie = 0; irq = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("t38_no_exc", 32'(exception), 32'h0);
        end
        clear_in();
        cycle();
        chk("t38_not_latched", 32'(exception), 32'h0);

        // Asynchronous reset in the middle of VECTOR.
        ill_instr = 1; pc_in = 32'h0000_3000;
        cycle(); clear_in();
        cycle();
        chk("t41_in_vector", 32'(vec_valid), 32'h1);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
        priv_viol = 1; pc_in = 32'h0000_3100;
        cycle(); clear_in();
        chk("t33_first_evt", 32'(cause), 32'd2);
        pc_ack = 1;
        cycle(); cycle(); clear_in();         // ENTER -> VECTOR -> HANDLER
        rfe_req = 1; cycle(); clear_in();
        pc_ack = 1; cycle(); clear_in();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            ill_instr = ($urandom_range(0, 15) == 0);
            priv_viol = ($urandom_range(0, 15) == 0);
            syscall   = ($urandom_range(0, 11) == 0);
            rfe_req   = ($urandom_range(0, 3) == 0);
            pc_ack    = ($urandom_range(0, 2) != 0);
            ie        = ($urandom_range(0, 1) == 1);
            irq       = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            pc_in     = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
